// File: rtl/avalon_to_wb_bridge.sv
// Avalon-MM slave to Wishbone B3 master bridge: one Avalon command at a time,
// single accesses become classic cycles, linear bursts become incrementing bursts.
`timescale 1ns/1ps

//  state | meaning
//  IDLE  | no cycle open; accepts reads at once, latches write commands
//  READ  | cyc/stb high, each terminated beat returns one readdatavalid
//  WRITE | cyc high, stb follows the Avalon write strobe beat by beat

module avalon_to_wb_bridge #(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [AW-1:0]     s_av_address_i,
   input  logic [DW/8-1:0]   s_av_byteenable_i,
   input  logic              s_av_read_i,
   input  logic              s_av_write_i,
   input  logic [DW-1:0]     s_av_writedata_i,
   input  logic [7:0]        s_av_burstcount_i,
   output logic [DW-1:0]     s_av_readdata_o,
   output logic              s_av_readdatavalid_o,
   output logic [1:0]        s_av_response_o,
   output logic              s_av_waitrequest_o,
   output logic [AW-1:0]     wbm_adr_o,
   output logic [DW-1:0]     wbm_dat_o,
   output logic [DW/8-1:0]   wbm_sel_o,
   output logic              wbm_we_o,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic [2:0]        wbm_cti_o,
   output logic [1:0]        wbm_bte_o,
   input  logic [DW-1:0]     wbm_dat_i,
   input  logic              wbm_ack_i,
   input  logic              wbm_err_i,
   input  logic              wbm_rty_i,
   output logic              wr_err_o
);

   localparam int            SW   = DW / 8;
   localparam logic [AW-1:0] STEP = AW'(SW);
   localparam logic [1:0]    RESP_OKAY   = 2'b00;
   localparam logic [1:0]    RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t          state;
   logic            cyc;
   logic            we;
   logic [AW-1:0]   adr;
   logic [SW-1:0]   sel;
   logic [7:0]      beats_left;
   logic            burst;
   logic [DW-1:0]   readdata;
   logic            rdv;
   logic [1:0]      resp;
   logic            wr_err;
   logic            stb;
   logic            term;
   logic            waitreq;

   assign stb  = cyc & (~we | s_av_write_i);
   // A retry never consumes the beat, even if a misbehaving slave raises ack with it.
   assign term = stb & ~wbm_rty_i & (wbm_ack_i | wbm_err_i);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         cyc        <= 1'b0;
         we         <= 1'b0;
         adr        <= '0;
         sel        <= '0;
         beats_left <= '0;
         burst      <= 1'b0;
         readdata   <= '0;
         rdv        <= 1'b0;
         resp       <= RESP_OKAY;
         wr_err     <= 1'b0;
      end else begin
         rdv    <= 1'b0;
         wr_err <= 1'b0;
         case (state)
            IDLE: begin
               if (s_av_read_i || s_av_write_i) begin
                  adr        <= s_av_address_i;
                  beats_left <= (s_av_burstcount_i == 8'd0) ? 8'd1 : s_av_burstcount_i;
                  burst      <= (s_av_burstcount_i > 8'd1);
                  cyc        <= 1'b1;
                  if (s_av_read_i) begin
                     sel   <= s_av_byteenable_i;
                     we    <= 1'b0;
                     state <= READ;
                  end else begin
                     we    <= 1'b1;
                     state <= WRITE;
                  end
               end
            end
            READ, WRITE: begin
               if (term) begin
                  adr        <= adr + STEP;
                  beats_left <= beats_left - 8'd1;
                  if (state == READ) begin
                     readdata <= wbm_dat_i;
                     rdv      <= 1'b1;
                     resp     <= wbm_err_i ? RESP_SLVERR : RESP_OKAY;
                  end else begin
                     wr_err   <= wbm_err_i;
                  end
                  if (beats_left == 8'd1) begin
                     state <= IDLE;
                     cyc   <= 1'b0;
                     we    <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               cyc   <= 1'b0;
               we    <= 1'b0;
            end
         endcase
      end
   end

   // Reads are accepted straight from IDLE; write beats are released as the slave ends them.
   always_comb begin
      waitreq = 1'b1;
      if (wb_rst_i)
         waitreq = 1'b1;
      else if (state == IDLE)
         waitreq = ~s_av_read_i;
      else if (state == WRITE)
         waitreq = ~term;
   end

   assign s_av_readdata_o      = readdata;
   assign s_av_readdatavalid_o = rdv;
   assign s_av_response_o      = resp;
   assign s_av_waitrequest_o   = waitreq;
   assign wbm_adr_o            = adr;
   assign wbm_dat_o            = s_av_writedata_i;
   assign wbm_sel_o            = we ? s_av_byteenable_i : (burst ? {SW{1'b1}} : sel);
   assign wbm_we_o             = we;
   assign wbm_cyc_o            = cyc;
   assign wbm_stb_o            = stb;
   assign wbm_cti_o            = (cyc && burst) ? ((beats_left > 8'd1) ? 3'b010 : 3'b111) : 3'b000;
   assign wbm_bte_o            = 2'b00;
   assign wr_err_o             = wr_err;

endmodule
